// File: rtl/frame_ctrl_pkg.sv
// Shared types and constants for the autonomous frame-control sequencing master.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        WR_SW0    = 2'd2,
        WR_SW1    = 2'd3
    } fsm_state_t;

    localparam logic [1:0] SW0_ADDR = 2'd0;
    localparam logic [1:0] SW1_ADDR = 2'd1;

    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_FCNT_W   = 16;

endpackage

// File: rtl/frame_period_timer.sv
// Loadable down-counter that paces frames; a load value of 0 behaves like 1.
module frame_period_timer
    import frame_ctrl_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                csi_clk,
    input  logic                rsi_reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_value,
    input  logic                run,
    output logic                zero
);

    logic [PERIOD_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            count <= '0;
        end else if (load) begin
            // max(period,1)-1: a zero period collapses to a single-cycle wait.
            count <= (load_value == '0) ? '0 : load_value - PERIOD_W'(1);
        end else if (run && (count != '0)) begin
            count <= count - PERIOD_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frame_sequence_master.sv
// Avalon-MM master that ping-pongs the SW0/SW1 buffer-select registers once per frame period.
module frame_sequence_master
    import frame_ctrl_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int FCNT_W   = DEF_FCNT_W
) (
    input  logic                csi_clk,
    input  logic                rsi_reset,
    input  logic                coe_c0_enable,
    input  logic [PERIOD_W-1:0] coe_c0_period,
    output logic                coe_c0_busy,
    output logic                coe_c0_bank,
    output logic [FCNT_W-1:0]   coe_c0_frame_cnt,
    output logic [1:0]          avm_m0_address,
    output logic                avm_m0_write,
    output logic [31:0]         avm_m0_writedata,
    input  logic                avm_m0_waitrequest
);

    fsm_state_t        state;
    logic              bank;
    logic [FCNT_W-1:0] frame_cnt;
    logic              timer_load;
    logic              timer_run;
    logic              timer_zero;
    logic              pair_done;

    // Write is always high in the WR states, so acceptance reduces to the slave not stalling.
    assign pair_done  = (state == WR_SW1) && !avm_m0_waitrequest;
    assign timer_load = ((state == IDLE) && coe_c0_enable) || pair_done;
    assign timer_run  = (state == WAIT_TICK);

    frame_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .csi_clk    (csi_clk),
        .rsi_reset  (rsi_reset),
        .load       (timer_load),
        .load_value (coe_c0_period),
        .run        (timer_run),
        .zero       (timer_zero)
    );

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state            <= IDLE;
            avm_m0_write     <= 1'b0;
            avm_m0_address   <= '0;
            avm_m0_writedata <= '0;
            bank             <= 1'b0;
            frame_cnt        <= '0;
            coe_c0_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coe_c0_enable) begin
                        state       <= WAIT_TICK;
                        coe_c0_busy <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (!coe_c0_enable) begin
                        state       <= IDLE;
                        coe_c0_busy <= 1'b0;
                    end else if (timer_zero) begin
                        state            <= WR_SW0;
                        avm_m0_write     <= 1'b1;
                        avm_m0_address   <= SW0_ADDR;
                        avm_m0_writedata <= {31'b0, bank};
                    end
                end
                WR_SW0: begin
                    if (!avm_m0_waitrequest) begin
                        state            <= WR_SW1;
                        avm_m0_address   <= SW1_ADDR;
                        avm_m0_writedata <= {31'b0, ~bank};
                    end
                end
                WR_SW1: begin
                    // Enable is only consulted once the pair has landed, so SW0/SW1 never end up equal.
                    if (!avm_m0_waitrequest) begin
                        bank             <= ~bank;
                        frame_cnt        <= frame_cnt + FCNT_W'(1);
                        avm_m0_write     <= 1'b0;
                        avm_m0_address   <= '0;
                        avm_m0_writedata <= '0;
                        if (coe_c0_enable) begin
                            state <= WAIT_TICK;
                        end else begin
                            state       <= IDLE;
                            coe_c0_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign coe_c0_bank      = bank;
    assign coe_c0_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_frame_sequence_master.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_frame_sequence_master;

    localparam int PERIOD_W = 24;
    localparam int FCNT_W   = 2;
    localparam int FMOD     = 1 << FCNT_W;

    logic                csi_clk;
    logic                rsi_reset;
    logic                coe_c0_enable;
    logic [PERIOD_W-1:0] coe_c0_period;
    logic                coe_c0_busy;
    logic                coe_c0_bank;
    logic [FCNT_W-1:0]   coe_c0_frame_cnt;
    logic [1:0]          avm_m0_address;
    logic                avm_m0_write;
    logic [31:0]         avm_m0_writedata;
    logic                avm_m0_waitrequest;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    frame_sequence_master #(
        .PERIOD_W (PERIOD_W),
        .FCNT_W   (FCNT_W)
    ) dut (
        .csi_clk            (csi_clk),
        .rsi_reset          (rsi_reset),
        .coe_c0_enable      (coe_c0_enable),
        .coe_c0_period      (coe_c0_period),
        .coe_c0_busy        (coe_c0_busy),
        .coe_c0_bank        (coe_c0_bank),
        .coe_c0_frame_cnt   (coe_c0_frame_cnt),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    initial begin
        csi_clk = 1'b0;
        forever #5 csi_clk = ~csi_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycles left before the next pair and writes still owed in the pair.
    bit m_running;
    int m_left;
    int m_pend;
    bit m_bank;
    int m_cnt;

    function automatic int clamp_period(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    always @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            m_running = 0;
            m_left    = 0;
            m_pend    = 0;
            m_bank    = 0;
            m_cnt     = 0;
        end else if (m_pend > 0) begin
            if (!avm_m0_waitrequest) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_bank    = ~m_bank;
                    m_cnt     = (m_cnt + 1) % FMOD;
                    m_left    = clamp_period(int'(coe_c0_period)) - 1;
                    m_running = coe_c0_enable;
                end
            end
        end else if (m_running) begin
            if (!coe_c0_enable)  m_running = 0;
            else if (m_left == 0) m_pend = 2;
            else                  m_left--;
        end else if (coe_c0_enable) begin
            m_running = 1;
            m_left    = clamp_period(int'(coe_c0_period)) - 1;
        end
    end

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge csi_clk) begin
        if (chk_on && !rsi_reset) begin
            check("m_write", 32'(avm_m0_write), 32'(m_pend > 0));
            check("m_address", 32'(avm_m0_address), 32'(m_pend == 1));
            check("m_writedata", avm_m0_writedata,
                  (m_pend > 0) ? 32'(m_bank ^ (m_pend == 1)) : 32'd0);
            check("m_busy", 32'(coe_c0_busy), 32'(m_running || (m_pend > 0)));
            check("m_bank", 32'(coe_c0_bank), 32'(m_bank));
            check("m_frame_cnt", 32'(coe_c0_frame_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge csi_clk);
        @(negedge csi_clk);
    endtask

    task automatic do_reset();
        rsi_reset          = 1'b1;
        coe_c0_enable      = 1'b0;
        coe_c0_period      = '0;
        avm_m0_waitrequest = 1'b0;
        repeat (2) @(negedge csi_clk);
        rsi_reset = 1'b0;
    endtask

    task automatic wait_wr(input logic [1:0] a, input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (avm_m0_write && (avm_m0_address == a)) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_wr: got no write to addr %0d required one within %0d cycles", a, max);
        end
    endtask

    initial begin
        int c;
        int c2;

        do_reset();
        chk_on = 1;
        check("rst_write", 32'(avm_m0_write), 32'd0);
        check("rst_addr", 32'(avm_m0_address), 32'd0);
        check("rst_data", avm_m0_writedata, 32'd0);
        check("rst_busy", 32'(coe_c0_busy), 32'd0);
        check("rst_bank", 32'(coe_c0_bank), 32'd0);
        check("rst_fcnt", 32'(coe_c0_frame_cnt), 32'd0);

        // Period 4: first SW0 five cycles after enable, then SW1, then a pair every 6 cycles.
        coe_c0_enable = 1'b1;
        coe_c0_period = 24'd4;
        wait_wr(2'd0, 20, c);
        check("a_first_latency", 32'(c), 32'd5);
        check("a_sw0_data", avm_m0_writedata, 32'd0);
        tick();
        check("a_sw1_addr", 32'(avm_m0_address), 32'd1);
        check("a_sw1_data", avm_m0_writedata, 32'd1);
        tick();
        check("a_idle_write", 32'(avm_m0_write), 32'd0);
        check("a_bank", 32'(coe_c0_bank), 32'd1);
        check("a_fcnt", 32'(coe_c0_frame_cnt), 32'd1);
        wait_wr(2'd0, 20, c2);
        check("a_pair_spacing", 32'(c2 + 2), 32'd6);
        check("a_sw0_data2", avm_m0_writedata, 32'd1);
        tick();
        check("a_sw1_data2", avm_m0_writedata, 32'd0);

        // Stall SW0 for three cycles.
        do_reset();
        coe_c0_enable      = 1'b1;
        coe_c0_period      = 24'd3;
        avm_m0_waitrequest = 1'b1;
        wait_wr(2'd0, 20, c);
        for (int k = 0; k < 3; k++) begin
            check("w_hold_write", 32'(avm_m0_write), 32'd1);
            check("w_hold_addr", 32'(avm_m0_address), 32'd0);
            check("w_hold_data", avm_m0_writedata, 32'd0);
            if (k < 2) tick();
        end
        avm_m0_waitrequest = 1'b0;
        tick();
        check("w_sw1_follows", 32'({avm_m0_write, avm_m0_address}), 32'b101);
        tick();
        check("w_single_pair", 32'(coe_c0_frame_cnt), 32'd1);

        // Enable drops while SW0 is stalled: the pair still completes, then IDLE.
        do_reset();
        coe_c0_enable      = 1'b1;
        coe_c0_period      = 24'd2;
        avm_m0_waitrequest = 1'b1;
        wait_wr(2'd0, 20, c);
        coe_c0_enable = 1'b0;
        tick();
        tick();
        check("e_still_sw0", 32'({avm_m0_write, avm_m0_address}), 32'b100);
        avm_m0_waitrequest = 1'b0;
        tick();
        check("e_sw1", 32'({avm_m0_write, avm_m0_address}), 32'b101);
        tick();
        check("e_fcnt", 32'(coe_c0_frame_cnt), 32'd1);
        check("e_busy", 32'(coe_c0_busy), 32'd0);
        repeat (4) tick();
        check("e_stays_idle", 32'({coe_c0_busy, avm_m0_write}), 32'd0);

        // Period 0 acts as period 1.
        do_reset();
        coe_c0_enable = 1'b1;
        wait_wr(2'd0, 20, c);
        wait_wr(2'd0, 20, c2);
        check("p0_spacing", 32'(c2), 32'd3);

        // Counter wrap at FCNT_W=2 with bank alternating.
        do_reset();
        coe_c0_enable = 1'b1;
        coe_c0_period = 24'd1;
        for (int k = 1; k <= 5; k++) begin
            wait_wr(2'd1, 20, c);
            tick();
            check("f_fcnt", 32'(coe_c0_frame_cnt), 32'(k % 4));
            check("f_bank", 32'(coe_c0_bank), 32'(k % 2));
        end

        // Asynchronous reset while SW1 is stalled.
        do_reset();
        coe_c0_enable = 1'b1;
        coe_c0_period = 24'd2;
        wait_wr(2'd1, 20, c);
        avm_m0_waitrequest = 1'b1;
        tick();
        tick();
        #2 rsi_reset = 1'b1;
        #1;
        check("r_write", 32'(avm_m0_write), 32'd0);
        check("r_addr", 32'(avm_m0_address), 32'd0);
        check("r_data", avm_m0_writedata, 32'd0);
        check("r_busy", 32'(coe_c0_busy), 32'd0);
        check("r_bank", 32'(coe_c0_bank), 32'd0);
        check("r_fcnt", 32'(coe_c0_frame_cnt), 32'd0);
        @(negedge csi_clk);

        // Randomized traffic, checked each cycle by the compare process.
        do_reset();
        coe_c0_enable = 1'b1;
        coe_c0_period = 24'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) coe_c0_enable = ~coe_c0_enable;
            avm_m0_waitrequest = ($urandom_range(2) == 0);
            if ($urandom_range(31) == 0) coe_c0_period = 24'($urandom_range(5));
            tick();
        end
        coe_c0_enable      = 1'b0;
        avm_m0_waitrequest = 1'b0;
        repeat (20) tick();
        check("end_idle", 32'(coe_c0_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
